// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl
//   Sequences one alarm ringing episode downstream of the alarm compare
//   datapath. Detects the match (t_main >= t_alarm while armed), drives a
//   1 Hz on/off buzzer pattern, and handles snooze, dismiss and ring timeout.
//   On dismiss (manual or automatic) it pulses alarm_clear so the alarm
//   register block disarms itself.
//
// Ports
//   clk          : system clock
//   reset        : synchronous active-high reset
//   tick_1hz     : one-cycle pulse per second
//   t_main       : current time in seconds (TW bits)
//   t_alarm      : programmed alarm time in seconds (TW bits)
//   alarm_active : alarm armed flag
//   snooze_btn   : one-cycle debounced snooze request
//   dismiss_btn  : one-cycle debounced dismiss request
//   buzzer       : buzzer drive, toggles each second while ringing
//   ringing      : high in RINGING
//   snoozed      : high in SNOOZE
//   snooze_cnt   : snoozes used in the current episode
//   alarm_clear  : one-cycle disarm request
//
// All outputs are registered; they reflect the state entered at the last edge.

module alarm_ring_ctrl #(
  parameter int unsigned TW           = 28,
  parameter int unsigned SNOOZE_SEC   = 300,
  parameter int unsigned RING_TIMEOUT = 60,
  parameter int unsigned MAX_SNOOZE   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_1hz,
  input  logic [TW-1:0] t_main,
  input  logic [TW-1:0] t_alarm,
  input  logic          alarm_active,
  input  logic          snooze_btn,
  input  logic          dismiss_btn,
  output logic          buzzer,
  output logic          ringing,
  output logic          snoozed,
  output logic [1:0]    snooze_cnt,
  output logic          alarm_clear
);

  localparam int unsigned RSW = $clog2(RING_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZE,
    WAIT_CLR
  } state_e;

  state_e          state_q, state_d;
  logic [RSW-1:0]  ring_sec_q, ring_sec_d;
  logic            phase_q, phase_d;
  logic [TW-1:0]   wake_time_q, wake_time_d;
  logic [1:0]      snooze_cnt_q, snooze_cnt_d;
  logic            alarm_clear_q, alarm_clear_d;
  logic            buzzer_q, ringing_q, snoozed_q;

  logic            can_snooze;
  logic            timeout;
  logic            do_snooze;
  logic            do_dismiss;

  assign can_snooze = (snooze_cnt_q < 2'(MAX_SNOOZE));
  assign timeout    = tick_1hz && (ring_sec_q == RSW'(RING_TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    ring_sec_d    = ring_sec_q;
    phase_d       = phase_q;
    wake_time_d   = wake_time_q;
    snooze_cnt_d  = snooze_cnt_q;
    alarm_clear_d = 1'b0;
    do_snooze     = 1'b0;
    do_dismiss    = 1'b0;

    case (state_q)
      IDLE: begin
        snooze_cnt_d = '0;
        // A tick in the match cycle is not counted: ring_sec starts at 0.
        if (alarm_active && (t_main >= t_alarm)) begin
          state_d    = RINGING;
          ring_sec_d = '0;
          phase_d    = 1'b1;
        end
      end

      RINGING: begin
        if (tick_1hz) begin
          phase_d    = ~phase_q;
          ring_sec_d = ring_sec_q + RSW'(1);
        end
        if (!alarm_active) begin
          state_d      = IDLE;
          snooze_cnt_d = '0;
        end else if (dismiss_btn) begin
          do_dismiss = 1'b1;
        end else if (snooze_btn && can_snooze) begin
          do_snooze = 1'b1;
        end else if (timeout) begin
          // Out of snoozes: the timeout turns into a dismiss.
          if (can_snooze) do_snooze  = 1'b1;
          else            do_dismiss = 1'b1;
        end
      end

      SNOOZE: begin
        if (!alarm_active) begin
          state_d      = IDLE;
          snooze_cnt_d = '0;
        end else if (dismiss_btn) begin
          do_dismiss = 1'b1;
        end else if (t_main >= wake_time_q) begin
          state_d    = RINGING;
          ring_sec_d = '0;
          phase_d    = 1'b1;
        end
      end

      WAIT_CLR: begin
        // Hold here until disarmed so a still-true match cannot retrigger.
        if (!alarm_active) begin
          state_d      = IDLE;
          snooze_cnt_d = '0;
        end
      end

      default: begin
        state_d      = IDLE;
        snooze_cnt_d = '0;
      end
    endcase

    if (do_dismiss) begin
      state_d       = WAIT_CLR;
      alarm_clear_d = 1'b1;
    end
    if (do_snooze) begin
      state_d      = SNOOZE;
      wake_time_d  = t_main + TW'(SNOOZE_SEC);
      snooze_cnt_d = snooze_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ring_sec_q    <= '0;
      phase_q       <= 1'b0;
      wake_time_q   <= '0;
      snooze_cnt_q  <= '0;
      alarm_clear_q <= 1'b0;
      buzzer_q      <= 1'b0;
      ringing_q     <= 1'b0;
      snoozed_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ring_sec_q    <= ring_sec_d;
      phase_q       <= phase_d;
      wake_time_q   <= wake_time_d;
      snooze_cnt_q  <= snooze_cnt_d;
      alarm_clear_q <= alarm_clear_d;
      // Outputs are decoded from the next state so they line up with state_q.
      buzzer_q      <= (state_d == RINGING) ? phase_d : 1'b0;
      ringing_q     <= (state_d == RINGING);
      snoozed_q     <= (state_d == SNOOZE);
    end
  end

  assign buzzer      = buzzer_q;
  assign ringing     = ringing_q;
  assign snoozed     = snoozed_q;
  assign snooze_cnt  = snooze_cnt_q;
  assign alarm_clear = alarm_clear_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl
//   Directed bench for alarm_ring_ctrl. Outputs are packed as
//   {buzzer, ringing, snoozed, snooze_cnt[1:0], alarm_clear} and compared
//   against hand-computed values one time unit after each rising edge.

module tb_alarm_ring_ctrl;

  localparam int unsigned TW = 28;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick_1hz;
  logic [TW-1:0] t_main;
  logic [TW-1:0] t_alarm;
  logic          alarm_active;
  logic          snooze_btn;
  logic          dismiss_btn;
  logic          buzzer;
  logic          ringing;
  logic          snoozed;
  logic [1:0]    snooze_cnt;
  logic          alarm_clear;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  alarm_ring_ctrl #(
    .TW           (TW),
    .SNOOZE_SEC   (300),
    .RING_TIMEOUT (60),
    .MAX_SNOOZE   (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick_1hz     (tick_1hz),
    .t_main       (t_main),
    .t_alarm      (t_alarm),
    .alarm_active (alarm_active),
    .snooze_btn   (snooze_btn),
    .dismiss_btn  (dismiss_btn),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozed      (snoozed),
    .snooze_cnt   (snooze_cnt),
    .alarm_clear  (alarm_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic b, input logic r, input logic s,
                                     input logic [1:0] c, input logic cl);
    return {26'd0, b, r, s, c, cl};
  endfunction

  function automatic logic [31:0] outs();
    return {26'd0, buzzer, ringing, snoozed, snooze_cnt, alarm_clear};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Each second: one idle cycle, then a tick cycle; outputs afterwards
  // reflect the edge that sampled the last tick.
  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      cyc();
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
    end
  endtask

  initial begin
    reset        = 1'b1;
    tick_1hz     = 1'b0;
    t_main       = 28'd99;
    t_alarm      = 28'd100;
    alarm_active = 1'b1;
    snooze_btn   = 1'b0;
    dismiss_btn  = 1'b0;
    cyc();
    cyc();
    check("reset_outputs", outs(), pk(0, 0, 0, 2'd0, 0));
    reset = 1'b0;

    // 1: match and buzzer toggling
    cyc();
    check("no_match_99", outs(), pk(0, 0, 0, 2'd0, 0));
    t_main = 28'd100;
    cyc();
    check("match_ring", outs(), pk(1, 1, 0, 2'd0, 0));
    cyc();
    check("no_tick_hold", outs(), pk(1, 1, 0, 2'd0, 0));
    ticks(1);
    check("tick1_buz0", outs(), pk(0, 1, 0, 2'd0, 0));
    ticks(1);
    check("tick2_buz1", outs(), pk(1, 1, 0, 2'd0, 0));

    // 2: manual snooze and wake
    t_main = 28'd120;
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    check("snooze_enter", outs(), pk(0, 0, 1, 2'd1, 0));
    t_main = 28'd419;
    cyc();
    check("snooze_hold_419", outs(), pk(0, 0, 1, 2'd1, 0));
    t_main = 28'd420;
    cyc();
    check("snooze_wake_420", outs(), pk(1, 1, 0, 2'd1, 0));

    // 3: snooze+dismiss together, dismiss wins; no retrigger while armed
    snooze_btn  = 1'b1;
    dismiss_btn = 1'b1;
    cyc();
    snooze_btn  = 1'b0;
    dismiss_btn = 1'b0;
    check("dismiss_clear_pulse", outs(), pk(0, 0, 0, 2'd1, 1));
    cyc();
    check("clear_one_cycle", outs(), pk(0, 0, 0, 2'd1, 0));
    for (int unsigned i = 0; i < 10; i++) cyc();
    check("wait_clr_no_rering", outs(), pk(0, 0, 0, 2'd1, 0));
    alarm_active = 1'b0;
    cyc();
    check("wait_clr_to_idle", outs(), pk(0, 0, 0, 2'd0, 0));

    // 4/5: match with tick in same cycle, timeouts, ignored snooze at max
    alarm_active = 1'b1;
    t_main   = 28'd1000;
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    check("match_with_tick", outs(), pk(1, 1, 0, 2'd0, 0));
    ticks(59);
    check("tick59_still_ring", outs(), pk(0, 1, 0, 2'd0, 0));
    ticks(1);
    check("auto_snooze1", outs(), pk(0, 0, 1, 2'd1, 0));
    t_main = 28'd1299;
    cyc();
    check("auto_wake_hold", outs(), pk(0, 0, 1, 2'd1, 0));
    t_main = 28'd1300;
    cyc();
    check("auto_wake1", outs(), pk(1, 1, 0, 2'd1, 0));
    ticks(60);
    check("auto_snooze2", outs(), pk(0, 0, 1, 2'd2, 0));
    t_main = 28'd1600;
    cyc();
    check("auto_wake2", outs(), pk(1, 1, 0, 2'd2, 0));
    ticks(60);
    check("auto_snooze3", outs(), pk(0, 0, 1, 2'd3, 0));
    t_main = 28'd1900;
    cyc();
    check("auto_wake3", outs(), pk(1, 1, 0, 2'd3, 0));
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    check("snooze_at_max_ignored", outs(), pk(1, 1, 0, 2'd3, 0));
    ticks(59);
    check("max_tick59_ring", outs(), pk(0, 1, 0, 2'd3, 0));
    ticks(1);
    check("auto_dismiss", outs(), pk(0, 0, 0, 2'd3, 1));
    cyc();
    check("auto_dismiss_wait", outs(), pk(0, 0, 0, 2'd3, 0));
    alarm_active = 1'b0;
    cyc();
    check("auto_dismiss_idle", outs(), pk(0, 0, 0, 2'd0, 0));

    // 6: reset mid-episode and cancel during snooze
    alarm_active = 1'b1;
    t_main = 28'd2000;
    cyc();
    check("ring_before_reset", outs(), pk(1, 1, 0, 2'd0, 0));
    reset = 1'b1;
    cyc();
    check("reset_in_ringing", outs(), pk(0, 0, 0, 2'd0, 0));
    reset = 1'b0;
    cyc();
    check("rering_after_reset", outs(), pk(1, 1, 0, 2'd0, 0));
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    check("snooze_before_reset", outs(), pk(0, 0, 1, 2'd1, 0));
    reset = 1'b1;
    cyc();
    check("reset_in_snooze", outs(), pk(0, 0, 0, 2'd0, 0));
    reset = 1'b0;
    cyc();
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    check("snooze_before_cancel", outs(), pk(0, 0, 1, 2'd1, 0));
    alarm_active = 1'b0;
    cyc();
    check("cancel_in_snooze", outs(), pk(0, 0, 0, 2'd0, 0));

    // Dismiss from SNOOZE
    alarm_active = 1'b1;
    cyc();
    snooze_btn = 1'b1;
    cyc();
    snooze_btn  = 1'b0;
    dismiss_btn = 1'b1;
    cyc();
    dismiss_btn = 1'b0;
    check("dismiss_in_snooze", outs(), pk(0, 0, 0, 2'd1, 1));
    alarm_active = 1'b0;
    cyc();
    check("dismiss_snooze_idle", outs(), pk(0, 0, 0, 2'd0, 0));

    // wake_time wraps: 2^28-100 + 300 = 200, already <= t_main, so the
    // snooze lasts a single cycle.
    alarm_active = 1'b1;
    t_main = 28'hFFF_FF9C;
    cyc();
    check("wrap_ring", outs(), pk(1, 1, 0, 2'd0, 0));
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    check("wrap_snooze", outs(), pk(0, 0, 1, 2'd1, 0));
    cyc();
    check("wrap_wake_immediate", outs(), pk(1, 1, 0, 2'd1, 0));
    alarm_active = 1'b0;
    cyc();
    check("wrap_cancel", outs(), pk(0, 0, 0, 2'd0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
